// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retirement buffer with result bypass and
// mispredict roll-back; one retire per cycle from the head entry.
module reorder_buffer #(
    parameter int ROB_DEPTH = 16,
    parameter int ID_W = 4,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            iss_valid,
    input  logic            iss_has_rd,
    input  logic [4:0]      iss_rd,
    input  logic            iss_is_branch,
    input  logic            iss_is_store,
    input  logic            iss_pred_taken,
    input  logic [XLEN-1:0] iss_pc,
    output logic [ID_W-1:0] alloc_id,
    output logic            full,
    input  logic            alu_valid,
    input  logic [ID_W-1:0] alu_id,
    input  logic [XLEN-1:0] alu_value,
    input  logic            alu_taken,
    input  logic [XLEN-1:0] alu_target,
    input  logic            lsb_valid,
    input  logic [ID_W-1:0] lsb_id,
    input  logic [XLEN-1:0] lsb_value,
    input  logic [ID_W-1:0] q1_id,
    input  logic [ID_W-1:0] q2_id,
    output logic            q1_ready,
    output logic            q2_ready,
    output logic [XLEN-1:0] q1_value,
    output logic [XLEN-1:0] q2_value,
    output logic            commit_valid,
    output logic [4:0]      commit_rd,
    output logic [XLEN-1:0] commit_value,
    output logic [ID_W-1:0] commit_id,
    output logic            store_commit,
    output logic            roll_back,
    output logic [XLEN-1:0] redirect_pc
);
    logic [ROB_DEPTH-1:0] busy, ready_q, has_rd_q, is_br_q, is_st_q, pred_q, taken_q;
    logic [4:0]      rd_q     [ROB_DEPTH];
    logic [XLEN-1:0] value_q  [ROB_DEPTH];
    logic [XLEN-1:0] target_q [ROB_DEPTH];
    logic [XLEN-1:0] pc_q     [ROB_DEPTH];
    logic [ID_W-1:0] head, tail;
    logic [ID_W:0]   count;
    logic do_iss, do_ret, mispred, do_flush, do_commit;
    logic q1_alu, q1_lsb, q2_alu, q2_lsb;

    assign full      = count == (ID_W+1)'(ROB_DEPTH);
    assign alloc_id  = tail;
    assign do_iss    = iss_valid & ~full & ~roll_back;
    assign do_ret    = busy[head] & ready_q[head] & ~roll_back;
    assign mispred   = is_br_q[head] & (taken_q[head] != pred_q[head]);
    assign do_flush  = do_ret & mispred;
    assign do_commit = do_ret & ~mispred;

    // Same-cycle writeback bypass so a dependent op need not wait an extra cycle
    assign q1_alu   = alu_valid & (alu_id == q1_id);
    assign q1_lsb   = lsb_valid & (lsb_id == q1_id);
    assign q2_alu   = alu_valid & (alu_id == q2_id);
    assign q2_lsb   = lsb_valid & (lsb_id == q2_id);
    assign q1_ready = q1_alu | q1_lsb | ready_q[q1_id];
    assign q2_ready = q2_alu | q2_lsb | ready_q[q2_id];
    assign q1_value = q1_alu ? alu_value : q1_lsb ? lsb_value : value_q[q1_id];
    assign q2_value = q2_alu ? alu_value : q2_lsb ? lsb_value : value_q[q2_id];

    always_ff @(posedge clk) begin
        if (rst) begin
            busy         <= '0;
            ready_q      <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            commit_valid <= 1'b0;
            store_commit <= 1'b0;
            roll_back    <= 1'b0;
            commit_rd    <= '0;
            commit_value <= '0;
            commit_id    <= '0;
            redirect_pc  <= '0;
        end else if (rdy) begin
            commit_valid <= do_commit;
            store_commit <= do_commit & is_st_q[head];
            roll_back    <= do_flush;
            if (do_commit) begin
                commit_rd    <= has_rd_q[head] ? rd_q[head] : 5'd0;
                commit_value <= value_q[head];
                commit_id    <= head;
            end
            if (do_flush) begin
                redirect_pc <= taken_q[head] ? target_q[head] : pc_q[head] + XLEN'(4);
                busy        <= '0;
                head        <= '0;
                tail        <= '0;
                count       <= '0;
            end else begin
                if (alu_valid & ~roll_back) begin
                    ready_q[alu_id]  <= 1'b1;
                    value_q[alu_id]  <= alu_value;
                    taken_q[alu_id]  <= alu_taken;
                    target_q[alu_id] <= alu_target;
                end
                if (lsb_valid & ~roll_back) begin
                    ready_q[lsb_id] <= 1'b1;
                    value_q[lsb_id] <= lsb_value;
                end
                if (do_iss) begin
                    busy[tail]     <= 1'b1;
                    ready_q[tail]  <= 1'b0;
                    has_rd_q[tail] <= iss_has_rd;
                    rd_q[tail]     <= iss_rd;
                    is_br_q[tail]  <= iss_is_branch;
                    is_st_q[tail]  <= iss_is_store;
                    pred_q[tail]   <= iss_pred_taken;
                    pc_q[tail]     <= iss_pc;
                    tail           <= tail + 1'b1;
                end
                if (do_commit) begin
                    busy[head] <= 1'b0;
                    head       <= head + 1'b1;
                end
                count <= count + {{ID_W{1'b0}}, do_iss} - {{ID_W{1'b0}}, do_commit};
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based model of program order.
module tb_reorder_buffer;
    localparam int D = 16;
    logic clk = 1'b0, rst, rdy;
    logic iss_valid, iss_has_rd, iss_is_branch, iss_is_store, iss_pred_taken;
    logic [4:0] iss_rd;
    logic [31:0] iss_pc;
    logic [3:0] alloc_id;
    logic full;
    logic alu_valid, alu_taken;
    logic [3:0] alu_id;
    logic [31:0] alu_value, alu_target;
    logic lsb_valid;
    logic [3:0] lsb_id;
    logic [31:0] lsb_value;
    logic [3:0] q1_id, q2_id;
    logic q1_ready, q2_ready;
    logic [31:0] q1_value, q2_value;
    logic commit_valid, store_commit, roll_back;
    logic [4:0] commit_rd;
    logic [31:0] commit_value, redirect_pc;
    logic [3:0] commit_id;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .iss_valid(iss_valid), .iss_has_rd(iss_has_rd), .iss_rd(iss_rd),
        .iss_is_branch(iss_is_branch), .iss_is_store(iss_is_store),
        .iss_pred_taken(iss_pred_taken), .iss_pc(iss_pc),
        .alloc_id(alloc_id), .full(full),
        .alu_valid(alu_valid), .alu_id(alu_id), .alu_value(alu_value),
        .alu_taken(alu_taken), .alu_target(alu_target),
        .lsb_valid(lsb_valid), .lsb_id(lsb_id), .lsb_value(lsb_value),
        .q1_id(q1_id), .q2_id(q2_id), .q1_ready(q1_ready), .q2_ready(q2_ready),
        .q1_value(q1_value), .q2_value(q2_value),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
        .commit_id(commit_id), .store_commit(store_commit),
        .roll_back(roll_back), .redirect_pc(redirect_pc)
    );

    // Model: program-ordered queue of live ids plus per-id fields
    int order[$];
    int m_tail;
    bit m_ready[D], m_has_rd[D], m_br[D], m_st[D], m_pt[D], m_tk[D];
    int unsigned m_rd[D], m_val[D], m_tgt[D], m_pc[D];
    bit e_cv, e_sc, e_rb;
    int unsigned e_rd, e_val, e_id, e_rpc;
    bit model_ok = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit live(input int id);
        foreach (order[i]) if (order[i] == id) return 1;
        return 0;
    endfunction

    task automatic chk_query(input string name, input logic [3:0] id, input logic r_o, input logic [31:0] v_o);
        bit r;
        int unsigned v;
        if (!live(id) || e_rb) return;
        r = m_ready[id];
        v = m_val[id];
        if (lsb_valid && lsb_id == id) begin r = 1; v = lsb_value; end
        if (alu_valid && alu_id == id) begin r = 1; v = alu_value; end
        chk({name, "_ready"}, r_o, r);
        if (r) chk({name, "_value"}, v_o, v);
    endtask

    task automatic model_step();
        int sz;
        int h;
        bit rb_now;
        sz = order.size();
        rb_now = e_rb;
        if (rst) begin
            order.delete();
            m_tail = 0;
            {e_cv, e_sc, e_rb} = '0;
            e_rd = 0; e_val = 0; e_id = 0; e_rpc = 0;
            foreach (m_ready[i]) m_ready[i] = 0;
            return;
        end
        if (!rdy) return;
        {e_cv, e_sc, e_rb} = '0;
        if (sz > 0 && !rb_now && m_ready[order[0]]) begin
            h = order[0];
            if (m_br[h] && m_tk[h] != m_pt[h]) begin
                e_rb = 1;
                e_rpc = m_tk[h] ? m_tgt[h] : m_pc[h] + 4;
                order.delete();
                m_tail = 0;
                return;
            end
            e_cv = 1;
            e_sc = m_st[h];
            e_rd = m_has_rd[h] ? m_rd[h] : 0;
            e_val = m_val[h];
            e_id = h;
            void'(order.pop_front());
        end
        if (rb_now) return;
        if (alu_valid) begin
            m_ready[alu_id] = 1; m_val[alu_id] = alu_value;
            m_tk[alu_id] = alu_taken; m_tgt[alu_id] = alu_target;
        end
        if (lsb_valid) begin
            m_ready[lsb_id] = 1; m_val[lsb_id] = lsb_value;
        end
        if (iss_valid && sz < D) begin
            h = m_tail;
            m_ready[h] = 0; m_has_rd[h] = iss_has_rd; m_rd[h] = iss_rd;
            m_br[h] = iss_is_branch; m_st[h] = iss_is_store;
            m_pt[h] = iss_pred_taken; m_pc[h] = iss_pc;
            order.push_back(h);
            m_tail = (m_tail + 1) % D;
        end
    endtask

    task automatic tick();
        #1;
        if (model_ok && !rst) begin
            chk("full", full, order.size() == D);
            chk("alloc_id", alloc_id, m_tail);
            chk_query("q1", q1_id, q1_ready, q1_value);
            chk_query("q2", q2_id, q2_ready, q2_value);
        end
        model_step();
        @(posedge clk);
        #1;
        if (rst) model_ok = 1;
        if (model_ok) begin
            chk("commit_valid", commit_valid, e_cv);
            chk("store_commit", store_commit, e_sc);
            chk("roll_back", roll_back, e_rb);
            chk("commit_rd", commit_rd, e_rd);
            chk("commit_value", commit_value, e_val);
            chk("commit_id", commit_id, e_id);
            chk("redirect_pc", redirect_pc, e_rpc);
        end
    endtask

    task automatic idle();
        rst = 0; rdy = 1;
        {iss_valid, iss_has_rd, iss_is_branch, iss_is_store, iss_pred_taken} = '0;
        iss_rd = 0; iss_pc = 0;
        alu_valid = 0; alu_id = 0; alu_value = 0; alu_taken = 0; alu_target = 0;
        lsb_valid = 0; lsb_id = 0; lsb_value = 0;
        q1_id = 0; q2_id = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic issue(input int rd, input bit has_rd, input bit br, input bit st, input bit pt, input int unsigned pc);
        iss_valid = 1; iss_rd = 5'(rd); iss_has_rd = has_rd; iss_is_branch = br;
        iss_is_store = st; iss_pred_taken = pt; iss_pc = pc;
        tick();
        iss_valid = 0;
    endtask

    task automatic wb_alu(input int id, input int unsigned v, input bit tk, input int unsigned tgt);
        alu_valid = 1; alu_id = 4'(id); alu_value = v; alu_taken = tk; alu_target = tgt;
        tick();
        alu_valid = 0;
    endtask

    task automatic rand_inputs();
        int cand[$];
        int k;
        rst = ($urandom_range(0, 599) == 0);
        rdy = ($urandom_range(0, 15) != 0);
        iss_valid = ($urandom_range(0, 2) != 0);
        iss_has_rd = $urandom_range(0, 1);
        iss_rd = 5'($urandom);
        iss_is_branch = ($urandom_range(0, 7) == 0);
        iss_is_store = !iss_is_branch && ($urandom_range(0, 5) == 0);
        iss_pred_taken = $urandom_range(0, 1);
        iss_pc = $urandom & 32'hFFFF_FFFC;
        foreach (order[i]) if (!m_ready[order[i]]) cand.push_back(order[i]);
        alu_valid = 0;
        lsb_valid = 0;
        if (cand.size() > 0 && $urandom_range(0, 1)) begin
            k = $urandom_range(0, cand.size() - 1);
            alu_valid = 1;
            alu_id = 4'(cand[k]);
            alu_value = $urandom;
            alu_target = $urandom & 32'hFFFF_FFFC;
            alu_taken = m_br[cand[k]] ? (($urandom_range(0, 3) == 0) ? !m_pt[cand[k]] : m_pt[cand[k]]) : 1'($urandom);
            cand.delete(k);
        end
        if (cand.size() > 0 && $urandom_range(0, 1)) begin
            lsb_valid = 1;
            lsb_id = 4'(cand[$urandom_range(0, cand.size() - 1)]);
            lsb_value = $urandom;
        end
        q1_id = (order.size() > 0 && $urandom_range(0, 3) != 0) ? 4'(order[$urandom_range(0, order.size() - 1)]) : 4'($urandom);
        q2_id = alu_valid && $urandom_range(0, 1) ? alu_id : 4'($urandom);
    endtask

    initial begin
        do_reset();
        chk("rst_full", full, 0);
        chk("rst_alloc_id", alloc_id, 0);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_roll_back", roll_back, 0);

        // Out-of-order writeback, in-order commit
        issue(1, 1, 0, 0, 0, 0);
        issue(2, 1, 0, 0, 0, 4);
        issue(3, 1, 0, 0, 0, 8);
        wb_alu(2, 30, 0, 0);
        wb_alu(0, 10, 0, 0);
        wb_alu(1, 20, 0, 0);
        chk("ooo_cv0", commit_valid, 1);
        chk("ooo_rd0", commit_rd, 1);
        chk("ooo_val0", commit_value, 10);
        chk("ooo_id0", commit_id, 0);
        tick();
        chk("ooo_rd1", commit_rd, 2);
        chk("ooo_val1", commit_value, 20);
        chk("ooo_id1", commit_id, 1);
        tick();
        chk("ooo_rd2", commit_rd, 3);
        chk("ooo_val2", commit_value, 30);
        chk("ooo_id2", commit_id, 2);
        tick();
        chk("ooo_cv_end", commit_valid, 0);

        // Fill, overflow attempt, wrap
        do_reset();
        for (int i = 0; i < 16; i++) issue(0, 0, 0, 0, 0, i * 4);
        chk("fill_full", full, 1);
        chk("fill_alloc", alloc_id, 0);
        issue(9, 1, 0, 0, 0, 32'h40);
        chk("over_full", full, 1);
        chk("over_alloc", alloc_id, 0);
        for (int i = 0; i < 4; i++) begin
            wb_alu(i, i + 100, 0, 0);
            if (i == 1) begin
                chk("over_not_written_rd", commit_rd, 0);
                chk("over_commit_id", commit_id, 0);
            end
        end
        tick();
        chk("wrap_not_full", full, 0);
        for (int i = 0; i < 4; i++) begin
            chk("wrap_alloc", alloc_id, 4'(i));
            issue(0, 0, 0, 0, 0, 32'h80);
        end
        chk("wrap_full", full, 1);

        // Mispredicted branch at head with three younger entries
        do_reset();
        issue(0, 0, 1, 0, 0, 32'h100);
        for (int i = 0; i < 3; i++) issue(5 + i, 1, 0, 0, 0, 32'h104 + i * 4);
        wb_alu(0, 0, 1, 32'h200);
        tick();
        chk("mp_roll_back", roll_back, 1);
        chk("mp_redirect", redirect_pc, 32'h200);
        chk("mp_cv", commit_valid, 0);
        chk("mp_alloc", alloc_id, 0);
        chk("mp_full", full, 0);
        issue(4, 1, 0, 0, 0, 32'h300);
        chk("mp_rb_pulse", roll_back, 0);
        chk("mp_alloc_after", alloc_id, 0);

        // Same-cycle bypass
        do_reset();
        for (int i = 0; i < 6; i++) issue(i + 1, 1, 0, 0, 0, 0);
        q1_id = 5; q2_id = 4;
        alu_valid = 1; alu_id = 5; alu_value = 32'hDEAD; alu_taken = 0; alu_target = 0;
        #1;
        chk("byp_q1_ready", q1_ready, 1);
        chk("byp_q1_value", q1_value, 32'hDEAD);
        chk("byp_q2_ready", q2_ready, 0);
        tick();
        alu_valid = 0;
        #1;
        chk("stored_q1_value", q1_value, 32'hDEAD);

        // Stall with a ready head
        do_reset();
        issue(7, 1, 0, 0, 0, 0);
        wb_alu(0, 32'h77, 0, 0);
        rdy = 0;
        repeat (3) begin
            tick();
            chk("stall_cv", commit_valid, 0);
        end
        rdy = 1;
        tick();
        chk("stall_cv_after", commit_valid, 1);
        chk("stall_rd", commit_rd, 7);
        chk("stall_val", commit_value, 32'h77);

        do_reset();
        repeat (4000) begin
            rand_inputs();
            tick();
        end
        idle();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
